div_pipe_arbiter: RTL and testbench

- Shares one fixed-latency pipelined divider (start / dividend / divisor in; data_valid / quotient / div_by_zero out) among NUM_REQ requesters.
- Round-robin grants at most one operation per cycle into the divider.
- Tags each issued operation with its requester id in a shift pipeline matched to the divider latency.
- Routes each returning result to the originating requester.
- Sits between the divider and the client blocks; the divider itself is unchanged.

---
 rtl/div_pipe_arb_pkg.sv | 40 ++++
 rtl/div_tag_pipe.sv | 40 ++++
 rtl/div_pipe_arbiter.sv | 189 ++++++++++++++++++
 tb/tb_div_pipe_arbiter.sv | 346 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/div_pipe_arb_pkg.sv
// div_pipe_arb_pkg
// Shared types and helpers for the pipelined-divider arbiter.
//   arb_state_t : arbiter control state (IDLE / RUN / DRAIN)
//   tag_t       : {valid, id} tag carried alongside each in-flight divide
//   rr_pick     : round-robin one-hot pick from a request vector and pointer
// MAX_REQ / MAX_ID_W bound the supported requester count (2..8).
package div_pipe_arb_pkg;

  localparam int MAX_REQ  = 8;
  localparam int MAX_ID_W = 3;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN
  } arb_state_t;

  typedef struct packed {
    logic                valid;
    logic [MAX_ID_W-1:0] id;
  } tag_t;

  // Search upward from ptr, wrapping at n; the first set request wins.
  // Only the low n bits of req are ever considered.
  function automatic logic [MAX_REQ-1:0] rr_pick(input logic [MAX_REQ-1:0]  req,
                                                 input logic [MAX_ID_W-1:0] ptr,
                                                 input int unsigned         n);
    logic [MAX_REQ-1:0]  gnt;
    logic [MAX_ID_W-1:0] idx;
    gnt = '0;
    for (int unsigned k = 0; k < MAX_REQ; k++) begin
      idx = MAX_ID_W'((32'(ptr) + k) % n);
      if (k < n && gnt == '0 && req[idx]) begin
        gnt[idx] = 1'b1;
      end
    end
    return gnt;
  endfunction

endpackage

// File: rtl/div_tag_pipe.sv
// div_tag_pipe
// Shift register of {valid, id} tags that travels in lock-step with the
// divider so that each returning result can be matched to its requester.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset (clears all stages)
//   in_tag     : tag loaded into stage 0 every cycle
//   tail       : last stage, lines up with the divider result strobe
//   any_valid  : at least one stage holds a valid tag
module div_tag_pipe
  import div_pipe_arb_pkg::*;
#(
  parameter int DEPTH = 10
) (
  input  logic clk,
  input  logic rst_n,
  input  tag_t in_tag,
  output tag_t tail,
  output logic any_valid
);

  tag_t [DEPTH-1:0] stage;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stage <= '0;
    end else begin
      stage <= {stage[DEPTH-2:0], in_tag};
    end
  end

  assign tail = stage[DEPTH-1];

  always_comb begin
    any_valid = 1'b0;
    for (int k = 0; k < DEPTH; k++) begin
      any_valid = any_valid | stage[k].valid;
    end
  end

endmodule

// File: rtl/div_pipe_arbiter.sv
// div_pipe_arbiter
// Shares one fixed-latency pipelined divider among NUM_REQ requesters.
// Round-robin grants at most one divide per cycle, tags it with the
// requester id, and routes the returning result back to that requester.
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   arb_en              : allow new grants (low = drain in-flight work)
//   req_valid/req_ready : per-requester request / one-hot combinational grant
//   req_dividend/divisor: packed operands, requester i at [i*WIDTH +: WIDTH]
//   div_start/div_*     : registered issue to the divider
//   div_data_valid/...  : divider result inputs
//   rsp_valid/rsp_*     : one-hot result pulse plus shared result bus
//   busy                : an op is being issued or is in flight
//   tag_err             : sticky, divider strobe disagreed with the tag pipe
// Optional: define DIV_PIPE_ARB_STATS_EN to add stat_issued / stat_dbz
// 16-bit wrapping counters of handshakes and divide-by-zero responses.
module div_pipe_arbiter
  import div_pipe_arb_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int WIDTH       = 4,
  parameter int DIV_LATENCY = 9
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     arb_en,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [NUM_REQ*WIDTH-1:0] req_dividend,
  input  logic [NUM_REQ*WIDTH-1:0] req_divisor,
  output logic                     div_start,
  output logic [WIDTH-1:0]         div_dividend,
  output logic [WIDTH-1:0]         div_divisor,
  input  logic                     div_data_valid,
  input  logic [WIDTH-1:0]         div_quotient,
  input  logic                     div_by_zero_in,
  output logic [NUM_REQ-1:0]       rsp_valid,
  output logic [WIDTH-1:0]         rsp_quotient,
  output logic                     rsp_div_by_zero,
  output logic                     busy,
  output logic                     tag_err
`ifdef DIV_PIPE_ARB_STATS_EN
  ,
  output logic [15:0]              stat_issued,
  output logic [15:0]              stat_dbz
`endif
);

  localparam int ID_W = $clog2(NUM_REQ);

  logic [ID_W-1:0]    ptr;
  logic [ID_W-1:0]    grant_idx;
  logic [MAX_REQ-1:0] gnt_full;
  logic               handshake;
  logic [WIDTH-1:0]   sel_dividend;
  logic [WIDTH-1:0]   sel_divisor;
  tag_t               in_tag;
  tag_t               tail;
  logic               pipe_busy;
  arb_state_t         state;

  // A grant is only ever given to a requester that is asserting valid, so
  // any grant bit is a handshake.
  always_comb begin
    gnt_full     = arb_en ? rr_pick(MAX_REQ'(req_valid), MAX_ID_W'(ptr), NUM_REQ) : '0;
    handshake    = |gnt_full;
    req_ready    = gnt_full[NUM_REQ-1:0];
    grant_idx    = '0;
    sel_dividend = '0;
    sel_divisor  = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (gnt_full[k]) begin
        grant_idx    = ID_W'(k);
        sel_dividend = req_dividend[k*WIDTH +: WIDTH];
        sel_divisor  = req_divisor[k*WIDTH +: WIDTH];
      end
    end
    in_tag = '{valid: handshake, id: MAX_ID_W'(grant_idx)};
  end

  // Pointer wraps explicitly so non-power-of-two NUM_REQ works.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr          <= '0;
      div_start    <= 1'b0;
      div_dividend <= '0;
      div_divisor  <= '0;
    end else begin
      div_start <= handshake;
      if (handshake) begin
        ptr          <= (grant_idx == ID_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
        div_dividend <= sel_dividend;
        div_divisor  <= sel_divisor;
      end
    end
  end

  // Stage 0 is valid alongside div_start, so DIV_LATENCY+1 stages put the
  // tail in the same cycle as the divider result strobe.
  div_tag_pipe #(
    .DEPTH(DIV_LATENCY + 1)
  ) u_tag_pipe (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_tag   (in_tag),
    .tail     (tail),
    .any_valid(pipe_busy)
  );

  // A strobe without a tag, or a tag without a strobe, is dropped and
  // latched as an error; only matched pairs produce a response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid       <= '0;
      rsp_quotient    <= '0;
      rsp_div_by_zero <= 1'b0;
      tag_err         <= 1'b0;
    end else begin
      rsp_valid <= '0;
      if (tail.valid && div_data_valid) begin
        rsp_valid       <= NUM_REQ'(1) << tail.id;
        rsp_quotient    <= div_quotient;
        rsp_div_by_zero <= div_by_zero_in;
      end
      if (tail.valid != div_data_valid) begin
        tag_err <= 1'b1;
      end
    end
  end

  // busy is registered alongside the state so it always equals state != IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      busy  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (handshake) begin
            state <= RUN;
            busy  <= 1'b1;
          end
        end
        RUN: begin
          if (!arb_en && pipe_busy) begin
            state <= DRAIN;
            busy  <= 1'b1;
          end else if (!pipe_busy && !handshake) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        DRAIN: begin
          if (handshake) begin
            state <= RUN;
            busy  <= 1'b1;
          end else if (!pipe_busy) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else if (arb_en) begin
            state <= RUN;
            busy  <= 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

`ifdef DIV_PIPE_ARB_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_issued <= '0;
      stat_dbz    <= '0;
    end else begin
      if (handshake) begin
        stat_issued <= stat_issued + 16'd1;
      end
      if ((|rsp_valid) && rsp_div_by_zero) begin
        stat_dbz <= stat_dbz + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_div_pipe_arbiter.sv
// tb_div_pipe_arbiter
// Self-checking bench for div_pipe_arbiter with a behavioural 9-cycle divider
// model. Expected responses go into a scoreboard queue when a request is
// granted and are compared when rsp_valid pulses.
module tb_div_pipe_arbiter;

  localparam int N   = 4;
  localparam int W   = 4;
  localparam int LAT = 9;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           arb_en = 1'b0;
  logic [N-1:0]   req_valid = '0;
  logic [N-1:0]   req_ready;
  logic [N*W-1:0] req_dividend = '0;
  logic [N*W-1:0] req_divisor = '0;
  logic           div_start;
  logic [W-1:0]   div_dividend;
  logic [W-1:0]   div_divisor;
  logic           div_data_valid;
  logic [W-1:0]   div_quotient;
  logic           div_by_zero_in;
  logic [N-1:0]   rsp_valid;
  logic [W-1:0]   rsp_quotient;
  logic           rsp_div_by_zero;
  logic           busy;
  logic           tag_err;
`ifdef DIV_PIPE_ARB_STATS_EN
  logic [15:0]    stat_issued;
  logic [15:0]    stat_dbz;
`endif

  div_pipe_arbiter #(
    .NUM_REQ(N),
    .WIDTH(W),
    .DIV_LATENCY(LAT)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .arb_en         (arb_en),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_dividend   (req_dividend),
    .req_divisor    (req_divisor),
    .div_start      (div_start),
    .div_dividend   (div_dividend),
    .div_divisor    (div_divisor),
    .div_data_valid (div_data_valid),
    .div_quotient   (div_quotient),
    .div_by_zero_in (div_by_zero_in),
    .rsp_valid      (rsp_valid),
    .rsp_quotient   (rsp_quotient),
    .rsp_div_by_zero(rsp_div_by_zero),
    .busy           (busy),
    .tag_err        (tag_err)
`ifdef DIV_PIPE_ARB_STATS_EN
    ,
    .stat_issued    (stat_issued),
    .stat_dbz       (stat_dbz)
`endif
  );

  always #5 clk = ~clk;

  // Divider model: not reset, like a real divider that keeps running
  // across an arbiter reset. Divide by zero returns all ones.
  logic [LAT-1:0]        mdl_v = '0;
  logic [LAT-1:0][W-1:0] mdl_q = '0;
  logic [LAT-1:0]        mdl_z = '0;
  logic                  inject_dv = 1'b0;
  logic [W-1:0]          inject_q = '0;

  always @(posedge clk) begin
    mdl_v <= {mdl_v[LAT-2:0], div_start};
    mdl_q <= {mdl_q[LAT-2:0], (div_divisor == '0) ? {W{1'b1}} : div_dividend / div_divisor};
    mdl_z <= {mdl_z[LAT-2:0], div_divisor == '0};
  end

  assign div_data_valid = mdl_v[LAT-1] | inject_dv;
  assign div_quotient   = inject_dv ? inject_q : mdl_q[LAT-1];
  assign div_by_zero_in = inject_dv ? 1'b0 : mdl_z[LAT-1];

  typedef struct {
    int           id;
    logic [W-1:0] q;
    logic         dbz;
  } exp_t;

  typedef struct {
    int           id;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] q;
    logic         dbz;
  } vec_t;

  exp_t sb[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;
  int   rsp_seen = 0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] expQ(input logic [W-1:0] a, input logic [W-1:0] b);
    return (b == '0) ? {W{1'b1}} : a / b;
  endfunction

  // Scoreboard side: every response pulse must match the oldest expectation.
  always @(negedge clk) begin
    if (rst_n && rsp_valid != '0) begin
      rsp_seen++;
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_rsp: rsp_valid=%b with nothing outstanding", rsp_valid);
      end else begin
        mon_e = sb.pop_front();
        checkOutput("rsp_valid", 32'(rsp_valid), 32'(1) << mon_e.id);
        checkOutput("rsp_quotient", 32'(rsp_quotient), 32'(mon_e.q));
        checkOutput("rsp_div_by_zero", 32'(rsp_div_by_zero), 32'(mon_e.dbz));
      end
    end
  end

  // Called at a negedge; raises one request, waits for its grant, pushes the
  // expectation and returns at the negedge just after the handshake edge.
  task automatic applyStimulus(input int id, input logic [W-1:0] a, input logic [W-1:0] b,
                               input logic [W-1:0] q, input logic dbz);
    int n = 0;
    req_valid[id]            = 1'b1;
    req_dividend[id*W +: W]  = a;
    req_divisor[id*W +: W]   = b;
    #1;
    while (!req_ready[id] && n < 50) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (n >= 50) begin
      checkOutput("grant_timeout", 32'(req_ready), 32'(1) << id);
    end else begin
      sb.push_back('{id: id, q: q, dbz: dbz});
    end
    @(negedge clk);
    req_valid[id] = 1'b0;
  endtask

  task automatic waitRsp(output int n);
    n = 0;
    while (rsp_valid == '0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (n >= 40) checkOutput("rsp_timeout", 32'(rsp_valid), 32'hFFFF_FFFF);
  endtask

  task automatic waitCount(input int target);
    int n = 0;
    while (rsp_seen < target && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) checkOutput("rsp_count_timeout", 32'(rsp_seen), 32'(target));
  endtask

  task automatic resetDut();
    rst_n = 1'b0;
    sb.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_div_start"}, 32'(div_start), 0);
    checkOutput({tag, "_div_dividend"}, 32'(div_dividend), 0);
    checkOutput({tag, "_div_divisor"}, 32'(div_divisor), 0);
    checkOutput({tag, "_rsp_valid"}, 32'(rsp_valid), 0);
    checkOutput({tag, "_rsp_quotient"}, 32'(rsp_quotient), 0);
    checkOutput({tag, "_rsp_dbz"}, 32'(rsp_div_by_zero), 0);
    checkOutput({tag, "_tag_err"}, 32'(tag_err), 0);
    checkOutput({tag, "_busy"}, 32'(busy), 0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL global_timeout: bench did not complete");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    vec_t vecs[8];
    int   lat;
    int   base;
    int   stat_list[5];

    vecs[0] = '{id: 2, a: 4'd6,  b: 4'd2, q: 4'd3,  dbz: 1'b0};
    vecs[1] = '{id: 1, a: 4'd5,  b: 4'd0, q: 4'hF,  dbz: 1'b1};
    vecs[2] = '{id: 0, a: 4'd15, b: 4'd4, q: 4'd3,  dbz: 1'b0};
    vecs[3] = '{id: 3, a: 4'd7,  b: 4'd7, q: 4'd1,  dbz: 1'b0};
    vecs[4] = '{id: 1, a: 4'd9,  b: 4'd1, q: 4'd9,  dbz: 1'b0};
    vecs[5] = '{id: 2, a: 4'd0,  b: 4'd3, q: 4'd0,  dbz: 1'b0};
    vecs[6] = '{id: 0, a: 4'd14, b: 4'd5, q: 4'd2,  dbz: 1'b0};
    vecs[7] = '{id: 3, a: 4'd15, b: 4'd0, q: 4'hF,  dbz: 1'b1};

    // Reset state
    repeat (2) @(negedge clk);
    checkResetOutputs("reset");
    rst_n  = 1'b1;
    arb_en = 1'b1;
    @(negedge clk);

    // Single op with exact timing: handshake edge E0, div_start after E0,
    // response after E0+10, busy low after E0+11.
    applyStimulus(vecs[0].id, vecs[0].a, vecs[0].b, vecs[0].q, vecs[0].dbz);
    checkOutput("issue_start", 32'(div_start), 1);
    checkOutput("issue_dividend", 32'(div_dividend), 6);
    checkOutput("issue_divisor", 32'(div_divisor), 2);
    checkOutput("issue_busy", 32'(busy), 1);
    @(negedge clk);
    checkOutput("start_single_pulse", 32'(div_start), 0);
    checkOutput("operand_hold", 32'(div_dividend), 6);
    waitRsp(lat);
    checkOutput("rsp_latency", 32'(lat), 9);
    checkOutput("busy_at_rsp", 32'(busy), 1);
    @(negedge clk);
    checkOutput("busy_after_rsp", 32'(busy), 0);

    // Table-driven single ops, including divide by zero
    for (int i = 1; i < 8; i++) begin
      applyStimulus(vecs[i].id, vecs[i].a, vecs[i].b, vecs[i].q, vecs[i].dbz);
      waitRsp(lat);
      @(negedge clk);
    end
    repeat (2) @(negedge clk);
    checkOutput("table_idle", 32'(busy), 0);

    // Fairness: all requesters always valid, pointer starts at 0 after reset
    resetDut();
    arb_en = 1'b1;
    for (int i = 0; i < N; i++) begin
      req_dividend[i*W +: W] = W'(8 + i);
      req_divisor[i*W +: W]  = W'(i + 1);
    end
    req_valid = '1;
    for (int k = 0; k < 8; k++) begin
      #1;
      checkOutput("rr_grant", 32'(req_ready), 32'(1) << (k % N));
      sb.push_back('{id: k % N, q: expQ(W'(8 + k % N), W'(k % N + 1)), dbz: 1'b0});
      @(negedge clk);
    end
    req_valid = '0;
    waitRsp(lat);
    for (int j = 1; j < 8; j++) begin
      @(negedge clk);
      checkOutput("b2b_rsp", 32'(|rsp_valid), 1);
    end
    repeat (3) @(negedge clk);

    // Drain: three ops then arb_en drops while requester 2 still asks
    base = rsp_seen;
    applyStimulus(0, 4'd12, 4'd3, expQ(4'd12, 4'd3), 1'b0);
    applyStimulus(1, 4'd10, 4'd2, expQ(4'd10, 4'd2), 1'b0);
    applyStimulus(3, 4'd8,  4'd0, expQ(4'd8, 4'd0),  1'b1);
    arb_en                 = 1'b0;
    req_dividend[2*W +: W] = 4'd9;
    req_divisor[2*W +: W]  = 4'd3;
    req_valid[2]           = 1'b1;
    #1;
    checkOutput("drain_no_grant", 32'(req_ready), 0);
    checkOutput("drain_busy", 32'(busy), 1);
    waitCount(base + 3);
    checkOutput("drain_still_no_grant", 32'(req_ready), 0);
    repeat (2) @(negedge clk);
    checkOutput("drain_idle", 32'(busy), 0);
    checkOutput("drain_rsp_count", 32'(rsp_seen - base), 3);
    arb_en = 1'b1;
    #1;
    checkOutput("arb_en_rise_grant", 32'(req_ready), 32'b0100);
    sb.push_back('{id: 2, q: expQ(4'd9, 4'd3), dbz: 1'b0});
    @(negedge clk);
    req_valid[2] = 1'b0;
    waitCount(base + 4);
    repeat (3) @(negedge clk);

    // Stray result with an empty tag pipe
    checkOutput("pre_err_tag_err", 32'(tag_err), 0);
    base      = rsp_seen;
    inject_q  = 4'd7;
    inject_dv = 1'b1;
    @(negedge clk);
    inject_dv = 1'b0;
    checkOutput("stray_tag_err", 32'(tag_err), 1);
    checkOutput("stray_no_rsp", 32'(rsp_valid), 0);
    repeat (3) @(negedge clk);
    checkOutput("tag_err_sticky", 32'(tag_err), 1);
    checkOutput("stray_rsp_count", 32'(rsp_seen - base), 0);

    // Reset mid-flight: outputs clear, the abandoned result later sets tag_err
    applyStimulus(3, 4'd9, 4'd3, 4'd3, 1'b0);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    sb.delete();
    checkResetOutputs("midreset");
    @(negedge clk);
    rst_n = 1'b1;
    base  = rsp_seen;
    @(negedge clk);
    checkOutput("post_reset_tag_err", 32'(tag_err), 0);
    repeat (12) @(negedge clk);
    checkOutput("abandoned_tag_err", 32'(tag_err), 1);
    checkOutput("abandoned_no_rsp", 32'(rsp_seen - base), 0);

    // Five back-to-back ops, two dividing by zero
    resetDut();
    arb_en       = 1'b1;
    base         = rsp_seen;
    stat_list    = '{1, 2, 3, 4, 7};
    for (int i = 0; i < 5; i++) begin
      applyStimulus(vecs[stat_list[i]].id, vecs[stat_list[i]].a, vecs[stat_list[i]].b,
                    vecs[stat_list[i]].q, vecs[stat_list[i]].dbz);
    end
    waitCount(base + 5);
    repeat (3) @(negedge clk);
    checkOutput("clean_tag_err", 32'(tag_err), 0);
    checkOutput("sb_empty", 32'(sb.size()), 0);
    checkOutput("final_idle", 32'(busy), 0);
`ifdef DIV_PIPE_ARB_STATS_EN
    checkOutput("stat_issued", 32'(stat_issued), 5);
    checkOutput("stat_dbz", 32'(stat_dbz), 2);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
